// File: rtl/rep_pixel_stream.sv
`default_nettype none
// ============================================================================
// Module      : rep_pixel_stream
// Description : Streaming nearest-neighbour upscaler (x1/x2/x4) with a
//               one-row line buffer and valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module rep_pixel_stream #(
    parameter int PIX_W = 8,
    parameter int SRC_W = 160,
    parameter int SRC_H = 120
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       factor_sel,
    input  logic             in_valid,
    input  logic [PIX_W-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [PIX_W-1:0] out_data,
    input  logic             out_ready,
    output logic             out_eol,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    localparam int COL_W = (SRC_W > 1) ? $clog2(SRC_W) : 1;
    localparam int ROW_W = (SRC_H > 1) ? $clog2(SRC_H) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(SRC_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SRC_H - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_EMIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       fm1_q, fm1_d;          // replication factor minus one
    logic [COL_W-1:0] src_col_q, src_col_d;
    logic [ROW_W-1:0] src_row_q, src_row_d;
    logic [1:0]       rep_x_q, rep_x_d;
    logic [1:0]       rep_y_q, rep_y_d;
    logic [PIX_W-1:0] line_q [SRC_W];

    logic w_in_fire;
    logic w_col_last;
    logic w_row_last;
    logic w_x_last;
    logic w_y_last;

    assign w_in_fire  = (state_q == S_LOAD) && in_valid;
    assign w_col_last = (src_col_q == COL_LAST);
    assign w_row_last = (src_row_q == ROW_LAST);
    assign w_x_last   = (rep_x_q == fm1_q);
    assign w_y_last   = (rep_y_q == fm1_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            fm1_q     <= 2'd0;
            src_col_q <= '0;
            src_row_q <= '0;
            rep_x_q   <= 2'd0;
            rep_y_q   <= 2'd0;
        end else begin
            state_q   <= state_d;
            fm1_q     <= fm1_d;
            src_col_q <= src_col_d;
            src_row_q <= src_row_d;
            rep_x_q   <= rep_x_d;
            rep_y_q   <= rep_y_d;
        end
    end

    // Line buffer keeps its contents across reset; it is always refilled before use.
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            line_q[src_col_q] <= in_data;
        end
    end

    always_comb begin
        state_d   = state_q;
        fm1_d     = fm1_q;
        src_col_d = src_col_q;
        src_row_d = src_row_q;
        rep_x_d   = rep_x_q;
        rep_y_d   = rep_y_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (factor_sel)
                        2'd1:    fm1_d = 2'd1;
                        2'd2:    fm1_d = 2'd3;
                        default: fm1_d = 2'd0;
                    endcase
                    src_col_d = '0;
                    src_row_d = '0;
                    rep_x_d   = 2'd0;
                    rep_y_d   = 2'd0;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    if (w_col_last) begin
                        src_col_d = '0;
                        state_d   = S_EMIT;
                    end else begin
                        src_col_d = src_col_q + COL_W'(1);
                    end
                end
            end
            S_EMIT: begin
                // Counter nesting: rep_x innermost, then src_col, then rep_y.
                if (out_ready) begin
                    if (!w_x_last) begin
                        rep_x_d = rep_x_q + 2'd1;
                    end else begin
                        rep_x_d = 2'd0;
                        if (!w_col_last) begin
                            src_col_d = src_col_q + COL_W'(1);
                        end else begin
                            src_col_d = '0;
                            if (!w_y_last) begin
                                rep_y_d = rep_y_q + 2'd1;
                            end else begin
                                rep_y_d = 2'd0;
                                if (w_row_last) begin
                                    state_d = S_DONE;
                                end else begin
                                    src_row_d = src_row_q + ROW_W'(1);
                                    state_d   = S_LOAD;
                                end
                            end
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == S_LOAD);
    assign out_valid = (state_q == S_EMIT);
    assign out_data  = out_valid ? line_q[src_col_q] : '0;
    assign out_eol   = out_valid && w_col_last && w_x_last;
    assign out_last  = out_eol && w_y_last && w_row_last;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_rep_pixel_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_rep_pixel_stream
// Description : Self-checking bench for rep_pixel_stream on a 4x3 source frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rep_pixel_stream;

    localparam int PW = 8;
    localparam int SW = 4;
    localparam int SH = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    factor_sel;
    logic          in_valid;
    logic [PW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [PW-1:0] out_data;
    logic          out_ready;
    logic          out_eol;
    logic          out_last;
    logic          busy;
    logic          done;

    rep_pixel_stream #(.PIX_W(PW), .SRC_W(SW), .SRC_H(SH)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .factor_sel (factor_sel),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .out_eol    (out_eol),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [PW-1:0] d;
        logic          eol;
        logic          last;
    } beat_t;

    typedef struct {
        logic [1:0] fsel;
        bit         rnd_in;
        bit         rnd_out;
        bit         toggle;
        int         beats;
    } frame_vec_t;

    beat_t      sbq[$];
    frame_vec_t tbl[5];
    int         vec  = 0;
    int         miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Called at a negedge; start is presented in the current cycle.
    task automatic run_frame(input logic [1:0] fsel, input bit rnd_in, input bit rnd_out,
                             input bit toggle, input int exp_beats);
        int            f;
        logic [PW-1:0] src [SW*SH];
        int            nbeats;
        f = (fsel == 2'd1) ? 2 : (fsel == 2'd2) ? 4 : 1;
        for (int i = 0; i < SW*SH; i++) src[i] = rnd_in ? PW'($urandom) : PW'(i);
        sbq.delete();
        for (int y = 0; y < SH*f; y++) begin
            for (int x = 0; x < SW*f; x++) begin
                beat_t b;
                b.d    = src[(y/f)*SW + x/f];
                b.eol  = (x == SW*f-1);
                b.last = b.eol && (y == SH*f-1);
                sbq.push_back(b);
            end
        end
        chk("frame_beats", 32'(sbq.size()), 32'(exp_beats));
        start      = 1'b1;
        factor_sel = fsel;
        @(negedge clk);
        start = 1'b0;
        chk("in_ready_after_start", {31'd0, in_ready}, 32'd1);
        nbeats = 0;
        fork
            begin : drv
                int idx = 0;
                int cyc = 0;
                while (idx < SW*SH && cyc < 5000) begin
                    @(negedge clk);
                    cyc++;
                    if (toggle) begin
                        start      = ($urandom_range(0, 3) == 0);
                        factor_sel = 2'($urandom);
                    end
                    in_valid = rnd_in ? ($urandom_range(0, 2) != 0) : 1'b1;
                    in_data  = src[idx];
                    if (in_valid && in_ready) idx++;
                end
                if (idx < SW*SH) chk("input_timeout", 32'(idx), 32'(SW*SH));
                @(negedge clk);
                in_valid = 1'b0;
                start    = 1'b0;
            end
            begin : mon
                int    cyc = 0;
                bit    stalled = 1'b0;
                beat_t held = '0;
                while (nbeats < exp_beats && cyc < 8000) begin
                    @(negedge clk);
                    cyc++;
                    out_ready = rnd_out ? 1'($urandom) : 1'b1;
                    if (out_valid) begin
                        chk("in_ready_emit", {31'd0, in_ready}, 32'd0);
                        if (stalled) chk("hold_stable", 32'({out_data, out_eol, out_last}), 32'(held));
                        if (sbq.size() == 0) begin
                            chk("extra_beat", 32'd1, 32'd0);
                        end else begin
                            chk("beat", 32'({out_data, out_eol, out_last}), 32'(sbq[0]));
                        end
                        held    = {out_data, out_eol, out_last};
                        stalled = !out_ready;
                        if (out_ready) begin
                            if (sbq.size() != 0) void'(sbq.pop_front());
                            nbeats++;
                        end
                    end
                end
                if (nbeats < exp_beats) chk("output_timeout", 32'(nbeats), 32'(exp_beats));
            end
        join
        @(negedge clk);
        out_ready = 1'b1;
        chk("done_pulse", {30'd0, done, busy}, {30'd0, 2'b11});
        @(negedge clk);
        chk("idle_after_done", {29'd0, done, busy, out_valid}, 32'd0);
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        tbl[0] = '{fsel: 2'd0, rnd_in: 1'b0, rnd_out: 1'b0, toggle: 1'b0, beats: 12};
        tbl[1] = '{fsel: 2'd1, rnd_in: 1'b0, rnd_out: 1'b0, toggle: 1'b0, beats: 48};
        tbl[2] = '{fsel: 2'd2, rnd_in: 1'b1, rnd_out: 1'b1, toggle: 1'b0, beats: 192};
        tbl[3] = '{fsel: 2'd3, rnd_in: 1'b0, rnd_out: 1'b0, toggle: 1'b0, beats: 12};
        tbl[4] = '{fsel: 2'd1, rnd_in: 1'b1, rnd_out: 1'b0, toggle: 1'b1, beats: 48};

        reset      = 1'b1;
        start      = 1'b0;
        factor_sel = 2'd0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {24'd0, out_data},
            32'd0);
        chk("reset_flags", {25'd0, in_ready, out_valid, out_eol, out_last, busy, done, 1'b0}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int t = 0; t < 5; t++) begin
            run_frame(tbl[t].fsel, tbl[t].rnd_in, tbl[t].rnd_out, tbl[t].toggle, tbl[t].beats);
        end

        // Reset asserted in the middle of an x2 emit band.
        start      = 1'b1;
        factor_sel = 2'd1;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h40;
        for (int i = 1; i < SW; i++) begin
            @(negedge clk);
            in_data = 8'h40 + PW'(i);
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("emit_first_pixel", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h40});
        repeat (3) @(negedge clk);
        chk("emit_before_reset", {31'd0, out_valid}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("reset_mid_emit", {21'd0, out_data, in_ready, out_valid, busy, done},
            32'd0);
        reset = 1'b0;
        begin
            int stray = 0;
            repeat (6) begin
                @(negedge clk);
                if (out_valid || busy) stray++;
            end
            chk("quiet_after_reset", 32'(stray), 32'd0);
        end
        run_frame(2'd0, 1'b0, 1'b0, 1'b0, 12);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
